// File: rtl/raster_scanner_if.sv
// Bundle between the rasterizer control, the scanner and the triangle tester.
// pt_valid qualifies px/py and pix_valid qualifies pix_*; neither has backpressure, so the tester takes one point every clock.
interface raster_scanner_if #(
  parameter int W  = 9,
  parameter int CW = 19
);
  logic          start;
  logic [W-1:0]  ax, bx, cx;
  logic [W-1:0]  ay, by, cy;
  logic [W-1:0]  px, py;
  logic          pt_valid;
  logic          S;
  logic          pix_valid;
  logic [W-1:0]  pix_x, pix_y;
  logic          pix_in;
  logic [CW-1:0] in_count;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  modport master (
    input  start, ax, bx, cx, ay, by, cy, S,
    output px, py, pt_valid, pix_valid, pix_x, pix_y, pix_in,
    output in_count, busy, done, dbg_state
  );

  modport slave (
    output start, ax, bx, cx, ay, by, cy, S,
    input  px, py, pt_valid, pix_valid, pix_x, pix_y, pix_in,
    input  in_count, busy, done, dbg_state
  );
endinterface

// File: rtl/raster_scanner.sv
// Walks the bounding box of a latched triangle one point per clock (y inner loop),
// re-aligns the tester's inside flag with its coordinate and counts inside pixels.
module raster_scanner #(
  parameter int W        = 9,
  parameter int TEST_LAT = 1,
  parameter int CW       = 19
) (
  input  logic             clk,
  input  logic             rst,
  raster_scanner_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BBOX  = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DW = (TEST_LAT > 1) ? $clog2(TEST_LAT) : 1;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  state_e        state_q, state_d;
  logic [W-1:0]  vx_q [3];
  logic [W-1:0]  vx_d [3];
  logic [W-1:0]  vy_q [3];
  logic [W-1:0]  vy_d [3];
  logic [W-1:0]  px_q, px_d, py_q, py_d;
  logic [W-1:0]  xmin, xmax, ymin, ymax;
  logic          pt_valid_q, pt_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] in_count_q, in_count_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          pv_q  [TEST_LAT];
  logic          pv_d  [TEST_LAT];
  logic [W-1:0]  pxs_q [TEST_LAT];
  logic [W-1:0]  pxs_d [TEST_LAT];
  logic [W-1:0]  pys_q [TEST_LAT];
  logic [W-1:0]  pys_d [TEST_LAT];
  logic          pix_v, pix_hit;

  assign xmin    = min3(vx_q[0], vx_q[1], vx_q[2]);
  assign xmax    = max3(vx_q[0], vx_q[1], vx_q[2]);
  assign ymin    = min3(vy_q[0], vy_q[1], vy_q[2]);
  assign ymax    = max3(vy_q[0], vy_q[1], vy_q[2]);
  assign pix_v   = pv_q[TEST_LAT-1];
  assign pix_hit = pix_v & bus.S;

  always_comb begin
    state_d    = state_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    px_d       = px_q;
    py_d       = py_q;
    pt_valid_d = pt_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drain_d    = drain_q;
    in_count_d = in_count_q;
    if (pix_hit && !(&in_count_q)) in_count_d = in_count_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          vx_d       = '{bus.ax, bus.bx, bus.cx};
          vy_d       = '{bus.ay, bus.by, bus.cy};
          in_count_d = '0;
          busy_d     = 1'b1;
          state_d    = BBOX;
        end
      end
      BBOX: begin
        px_d       = xmin;
        py_d       = ymin;
        pt_valid_d = 1'b1;
        state_d    = SCAN;
      end
      SCAN: begin
        // The corner point stops the walk before any increment, so 511 never wraps.
        if (px_q == xmax && py_q == ymax) begin
          pt_valid_d = 1'b0;
          drain_d    = DW'(TEST_LAT - 1);
          state_d    = DRAIN;
        end else if (py_q < ymax) begin
          py_d = py_q + W'(1);
        end else begin
          py_d = ymin;
          px_d = px_q + W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Coordinates only advance with a valid entry, so pix_x/pix_y hold between results.
  always_comb begin
    pv_d[0]  = pt_valid_q;
    pxs_d[0] = pt_valid_q ? px_q : pxs_q[0];
    pys_d[0] = pt_valid_q ? py_q : pys_q[0];
    for (int i = 1; i < TEST_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pxs_d[i] = pv_q[i-1] ? pxs_q[i-1] : pxs_q[i];
      pys_d[i] = pv_q[i-1] ? pys_q[i-1] : pys_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      px_q       <= '0;
      py_q       <= '0;
      pt_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= '0;
      in_count_q <= '0;
    end else begin
      state_q    <= state_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pt_valid_q <= pt_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
      in_count_q <= in_count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TEST_LAT; i++) begin
        pv_q[i]  <= 1'b0;
        pxs_q[i] <= '0;
        pys_q[i] <= '0;
      end
    end else begin
      pv_q  <= pv_d;
      pxs_q <= pxs_d;
      pys_q <= pys_d;
    end
  end

  assign bus.px        = px_q;
  assign bus.py        = py_q;
  assign bus.pt_valid  = pt_valid_q;
  assign bus.pix_valid = pix_v;
  assign bus.pix_x     = pxs_q[TEST_LAT-1];
  assign bus.pix_y     = pys_q[TEST_LAT-1];
  assign bus.pix_in    = pix_hit;
  assign bus.in_count  = in_count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_raster_scanner.sv
// Bench for raster_scanner: a TEST_LAT=1 and a TEST_LAT=3 instance run the same scans side by side,
// each with a registered tester stub; monitors pop expected points/results from queues.
module tb_raster_scanner;
  localparam int W  = 9;
  localparam int CW = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic         start = 1'b0;
  logic [W-1:0] ax = '0, bx = '0, cx = '0, ay = '0, by = '0, cy = '0;
  int           mode = 0;
  int           t0 = 0;

  raster_scanner_if #(.W(W), .CW(CW)) bus1 ();
  raster_scanner_if #(.W(W), .CW(CW)) bus3 ();

  assign bus1.start = start;
  assign bus1.ax = ax; assign bus1.bx = bx; assign bus1.cx = cx;
  assign bus1.ay = ay; assign bus1.by = by; assign bus1.cy = cy;
  assign bus3.start = start;
  assign bus3.ax = ax; assign bus3.bx = bx; assign bus3.cx = cx;
  assign bus3.ay = ay; assign bus3.by = by; assign bus3.cy = cy;

  raster_scanner #(.W(W), .TEST_LAT(1), .CW(CW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  raster_scanner #(.W(W), .TEST_LAT(3), .CW(CW)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // ---------------- tester stubs ----------------
  function automatic logic stub_f(input int m, input logic [W-1:0] x, input logic [W-1:0] y);
    case (m)
      0:       return 1'b1;
      1:       return ~(x[0] ^ y[0]);
      default: return 1'b0;
    endcase
  endfunction

  logic       s1_q;
  logic [2:0] s3_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s3_q <= '0;
    end else begin
      s1_q <= bus1.pt_valid & stub_f(mode, bus1.px, bus1.py);
      s3_q <= {s3_q[1:0], bus3.pt_valid & stub_f(mode, bus3.px, bus3.py)};
    end
  end
  assign bus1.S = s1_q;
  assign bus3.S = s3_q[2];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [2*W-1:0] pt_q1 [$];
  logic [2*W-1:0] pt_q3 [$];
  logic [2*W:0]   pix_q1 [$];
  logic [2*W:0]   pix_q3 [$];

  int npts1, first1, last1, lastpix1, ndone1 = 0, donec1;
  int npts3, first3, last3, lastpix3, ndone3 = 0, donec3;
  logic [CW-1:0] dcount1, dcount3;

  always @(negedge clk) begin
    int c;
    c = edge_cnt - t0 + 1;
    if (!rst) begin
      if (bus1.pt_valid) begin
        npts1++;
        if (first1 < 0) first1 = c;
        last1 = c;
        if (pt_q1.size() == 0) chk("pt1_extra", 1, 0);
        else chk("pt1", {bus1.px, bus1.py}, pt_q1.pop_front());
      end
      if (bus1.pix_valid) begin
        lastpix1 = c;
        if (pix_q1.size() == 0) chk("pix1_extra", 1, 0);
        else chk("pix1", {bus1.pix_x, bus1.pix_y, bus1.pix_in}, pix_q1.pop_front());
      end
      if (bus1.done) begin
        ndone1++;
        donec1  = c;
        dcount1 = bus1.in_count;
      end
    end
  end

  always @(negedge clk) begin
    int c;
    c = edge_cnt - t0 + 1;
    if (!rst) begin
      if (bus3.pt_valid) begin
        npts3++;
        if (first3 < 0) first3 = c;
        last3 = c;
        if (pt_q3.size() == 0) chk("pt3_extra", 1, 0);
        else chk("pt3", {bus3.px, bus3.py}, pt_q3.pop_front());
      end
      if (bus3.pix_valid) begin
        lastpix3 = c;
        if (pix_q3.size() == 0) chk("pix3_extra", 1, 0);
        else chk("pix3", {bus3.pix_x, bus3.pix_y, bus3.pix_in}, pix_q3.pop_front());
      end
      if (bus3.done) begin
        ndone3++;
        donec3  = c;
        dcount3 = bus3.in_count;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_zero(input string tag);
    chk({tag, "_zero1"}, {bus1.px, bus1.py, bus1.pt_valid, bus1.pix_valid, bus1.pix_x, bus1.pix_y,
                          bus1.pix_in, bus1.in_count, bus1.busy, bus1.done}, 64'd0);
    chk({tag, "_zero3"}, {bus3.px, bus3.py, bus3.pt_valid, bus3.pix_valid, bus3.pix_x, bus3.pix_y,
                          bus3.pix_in, bus3.in_count, bus3.busy, bus3.done}, 64'd0);
  endtask

  task automatic flush_queues();
    pt_q1.delete(); pt_q3.delete(); pix_q1.delete(); pix_q3.delete();
  endtask

  task automatic run_scan(input logic [W-1:0] iax, iay, ibx, iby, icx, icy,
                          input int xmin, xmax, ymin, ymax, input int m, input int exp_in,
                          input int poke, input int rstc, input string tag);
    int n, nd1, nd3, k;
    logic timed_out;
    n = (xmax - xmin + 1) * (ymax - ymin + 1);
    mode = m;
    flush_queues();
    for (int x = xmin; x <= xmax; x++) begin
      for (int y = ymin; y <= ymax; y++) begin
        pt_q1.push_back({W'(x), W'(y)});
        pt_q3.push_back({W'(x), W'(y)});
        pix_q1.push_back({W'(x), W'(y), stub_f(m, W'(x), W'(y))});
        pix_q3.push_back({W'(x), W'(y), stub_f(m, W'(x), W'(y))});
      end
    end
    npts1 = 0; first1 = -1; last1 = -1; lastpix1 = -1; donec1 = -1;
    npts3 = 0; first3 = -1; last3 = -1; lastpix3 = -1; donec3 = -1;
    nd1 = ndone1; nd3 = ndone3;
    @(negedge clk);
    ax = iax; ay = iay; bx = ibx; by = iby; cx = icx; cy = icy;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = edge_cnt;
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      k = edge_cnt - t0;
      if (poke > 0 && k == poke - 1) begin
        start = 1'b1;
        ax = 9'd100; ay = 9'd100; bx = 9'd0; by = 9'd0; cx = 9'd50; cy = 9'd7;
      end else begin
        start = 1'b0;
      end
      if (rstc > 0 && k == rstc - 1) begin
        rst = 1'b1;
        #1;
        chk_zero({tag, "_abort"});
        flush_queues();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk({tag, "_nodone1"}, ndone1, nd1);
        chk({tag, "_nodone3"}, ndone3, nd3);
        return;
      end
      if (!bus1.busy && !bus3.busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_npts1"}, npts1, n);
    chk({tag, "_npts3"}, npts3, n);
    chk({tag, "_first1"}, first1, 2);
    chk({tag, "_last1"}, last1, n + 1);
    chk({tag, "_first3"}, first3, 2);
    chk({tag, "_lastpix1"}, lastpix1, n + 2);
    chk({tag, "_lastpix3"}, lastpix3, n + 4);
    chk({tag, "_ndone1"}, ndone1 - nd1, 1);
    chk({tag, "_ndone3"}, ndone3 - nd3, 1);
    chk({tag, "_donecyc1"}, donec1, n + 3);
    chk({tag, "_donecyc3"}, donec3, n + 5);
    chk({tag, "_count1"}, dcount1, exp_in);
    chk({tag, "_count3"}, dcount3, exp_in);
    chk({tag, "_hold1"}, bus1.in_count, exp_in);
    chk({tag, "_left"}, pt_q1.size() + pt_q3.size() + pix_q1.size() + pix_q3.size(), 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_scan(9'd3, 9'd3, 9'd6, 9'd12, 9'd9, 9'd8, 3, 9, 3, 12, 0, 70, 0, 0, "tri_all");
    run_scan(9'd3, 9'd3, 9'd6, 9'd12, 9'd9, 9'd8, 3, 9, 3, 12, 1, 35, 0, 0, "tri_even");
    run_scan(9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 5, 5, 5, 5, 2, 0, 0, 0, "degen");
    run_scan(9'd0, 9'd0, 9'd511, 9'd0, 9'd255, 9'd0, 0, 511, 0, 0, 0, 512, 0, 0, "edge");
    run_scan(9'd3, 9'd3, 9'd6, 9'd12, 9'd9, 9'd8, 3, 9, 3, 12, 0, 70, 20, 0, "poke");
    run_scan(9'd3, 9'd3, 9'd6, 9'd12, 9'd9, 9'd8, 3, 9, 3, 12, 0, 70, 0, 30, "abort");
    run_scan(9'd3, 9'd3, 9'd6, 9'd12, 9'd9, 9'd8, 3, 9, 3, 12, 0, 70, 0, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
